riscv_reg_file_mp: RTL and testbench
====================================

Name: riscv_reg_file_mp

Overview:
- Parametrised multi-read-port integer register file for the RV32IM core. It generalises the architectural register configuration (XLEN, REG_COUNT) to any width, any register count and N read ports.
- Adds a post-reset hardware clear sequencer, hardwired x0 and a dropped-write indicator.
- Sits between the decode stage (read) and the writeback stage (write).

Parameters:
- XLEN, 32, data width in bits.
- REG_COUNT, 32, number of architectural registers. Must be a power of two and at least 2; 16 gives RV32E.
- NUM_RD_PORTS, 2, number of independent read ports, range 1..4.
- REG_ADDR_WIDTH, $clog2(REG_COUNT), derived; not to be overridden.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  synchronous reset, active-high
- rd_addr_i  input  NUM_RD_PORTS*REG_ADDR_WIDTH  read addresses; port p at slice [p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
- rd_data_o  output  NUM_RD_PORTS*XLEN  read data; port p at slice [p*XLEN +: XLEN]
- we_i  input  1  write enable
- wr_addr_i  input  REG_ADDR_WIDTH  write address
- wr_data_i  input  XLEN  write data
- init_busy_o  output  1  registered; high while the clear sequence runs
- wr_drop_o  output  1  registered; one-cycle pulse when a write is discarded during INIT

Behaviour:
- Clock and reset: single clock domain. rst_i is synchronous and active-high.
- FSM states:
  - RF_INIT:
    - Entered on any clock edge with rst_i=1; clear_idx <= 1.
    - Each edge with rst_i=0: regs[clear_idx] <= 0.
    - If clear_idx == REG_COUNT-1, go to RF_READY; otherwise clear_idx++.
  - RF_READY: normal operation. The FSM stays here until the next reset.
- Reset values:
  - init_busy_o=1, wr_drop_o=0, state=RF_INIT, clear_idx=1.
  - The register array is not reset directly; it is cleared by the sequencer.
- Clear latency: init_busy_o stays high for exactly REG_COUNT-1 cycles after rst_i deasserts (31 for the default). It falls on the edge that clears the last register.
- Reset mid-INIT: clear_idx restarts at 1 and the full sequence repeats. Reset in RF_READY re-enters RF_INIT.
- Writes:
  - In RF_READY with we_i=1 and wr_addr_i != 0: regs[wr_addr_i] <= wr_data_i at the clock edge.
  - A write to x0 is silently ignored; no wr_drop_o.
  - In RF_INIT with we_i=1: the write is discarded and wr_drop_o=1 the next cycle, regardless of address.
- Reads:
  - Combinational from the array.
  - Address 0 always returns 0.
  - During RF_INIT every port returns 0.
  - All read ports are independent; identical addresses on several ports are legal.
- Same-cycle read/write of the same nonzero address: result depends on RF_BYPASS_EN (see Optional Feature).
- Widths:
  - No arithmetic on data.
  - clear_idx is REG_ADDR_WIDTH bits wide. It never wraps, because the terminal compare precedes the increment.

Optional Feature:
- Macro: RISCV_RF_BYPASS_EN.
- Defined: each read port whose address equals wr_addr_i (nonzero) while we_i=1 in RF_READY returns wr_data_i in the same cycle (write-through).
- Not defined: the port returns the old register content; the new value is visible from the next cycle.
- x0 and RF_INIT rules apply in both cases.

Decomposition:
- Shared package riscv_rf_pkg:
  - typedef enum logic {RF_INIT, RF_READY} rf_state_e.
  - Localparam defaults taken from the core config package (XLEN, REG_COUNT, REG_ADDR_WIDTH).
- Sub-module riscv_rf_read_port:
  - One address decode/mux plus the x0, INIT and bypass qualification.
  - Instantiated NUM_RD_PORTS times via generate.

Test Plan:
1. Pulse rst_i for 1 cycle, then release -> init_busy_o=1 for exactly 31 cycles, then 0; rd_data_o reads 0 on all ports for every address 0..31.
2. READY: write x5=32'hDEADBEEF, next cycle read x5 on port0 and port1 -> both 32'hDEADBEEF. Write x0=32'h1234 -> x0 reads 0, wr_drop_o stays 0.
3. Assert we_i (x7=32'hA5A5A5A5) on cycle 10 of INIT -> wr_drop_o=1 for one cycle; after INIT, x7 reads 0.
4. Same-cycle write x3=32'h0000_00FF and read x3, prior value 32'h11 -> 32'hFF with RISCV_RF_BYPASS_EN, 32'h11 without; 32'hFF on the following cycle in both builds.
5. Re-assert rst_i at cycle 15 of INIT after writing x20=32'hCAFE earlier in READY -> busy runs a full 31 cycles from the new release; x20 reads 0.
6. REG_COUNT=16, NUM_RD_PORTS=3 -> INIT lasts 15 cycles; three ports reading x1, x15, x0 after writes of 1 and 15 return 1, 15, 0.

Source files
------------

// File: rtl/riscv_rf_pkg.sv
// Shared types and default sizing for the multi-read-port integer register file.
// Optional write-through bypass is enabled with RISCV_RF_BYPASS_EN.
package riscv_rf_pkg;

    typedef enum logic {
        RF_INIT,
        RF_READY
    } rf_state_e;

    // Defaults mirror the core configuration (RV32I/M)
    localparam int RF_XLEN           = 32;
    localparam int RF_REG_COUNT      = 32;
    localparam int RF_REG_ADDR_WIDTH = $clog2(RF_REG_COUNT);

endpackage

// File: rtl/riscv_rf_read_port.sv
// One combinational read port: array mux, optional forward of the in-flight write,
// and forcing to zero for x0 and while the clear sequence runs.
module riscv_rf_read_port
    import riscv_rf_pkg::*;
#(
    parameter int XLEN           = RF_XLEN,
    parameter int REG_COUNT      = RF_REG_COUNT,
    parameter int REG_ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic [REG_COUNT-1:0][XLEN-1:0] regs_i,
    input  logic [REG_ADDR_WIDTH-1:0]      rd_addr_i,
    input  logic                           rd_en_i,
    input  logic                           fwd_vld_i,
    input  logic [REG_ADDR_WIDTH-1:0]      fwd_addr_i,
    input  logic [XLEN-1:0]                fwd_data_i,
    output logic [XLEN-1:0]                rd_data_o
);

    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
        if (fwd_vld_i && (fwd_addr_i == rd_addr_i)) begin
            rd_data_o = fwd_data_i;
        end
        // x0 and the clear window take priority over everything else
        if (!rd_en_i || (rd_addr_i == '0)) begin
            rd_data_o = '0;
        end
    end

endmodule

// File: rtl/riscv_reg_file_mp.sv
// Parametrised N-read/1-write integer register file with post-reset clear sequencer,
// hardwired x0 and dropped-write flag. Write-through bypass under RISCV_RF_BYPASS_EN.
module riscv_reg_file_mp
    import riscv_rf_pkg::*;
#(
    parameter int XLEN           = RF_XLEN,
    parameter int REG_COUNT      = RF_REG_COUNT,
    parameter int NUM_RD_PORTS   = 2,
    parameter int REG_ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD_PORTS*XLEN-1:0]           rd_data_o,
    input  logic                                   we_i,
    input  logic [REG_ADDR_WIDTH-1:0]              wr_addr_i,
    input  logic [XLEN-1:0]                        wr_data_i,
    output logic                                   init_busy_o,
    output logic                                   wr_drop_o
);

    localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = REG_ADDR_WIDTH'(REG_COUNT - 1);

    rf_state_e                      state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0]      clear_idx_q, clear_idx_d;
    logic                           init_busy_q, init_busy_d;
    logic                           wr_drop_q, wr_drop_d;
    logic [REG_COUNT-1:0][XLEN-1:0] regs_q, regs_d;
    logic                           fwd_vld;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RF_INIT;
            clear_idx_q <= REG_ADDR_WIDTH'(1);
            init_busy_q <= 1'b1;
            wr_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            init_busy_q <= init_busy_d;
            wr_drop_q   <= wr_drop_d;
        end
    end

    // Terminal compare comes before the increment, so clear_idx never wraps
    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        case (state_q)
            RF_INIT: begin
                if (clear_idx_q == LAST_IDX) begin
                    state_d = RF_READY;
                end else begin
                    clear_idx_d = clear_idx_q + REG_ADDR_WIDTH'(1);
                end
            end
            default: state_d = RF_READY;
        endcase
    end

    always_comb begin
        init_busy_d = (state_d == RF_INIT);
        wr_drop_d   = we_i && (state_q == RF_INIT);
    end

    // Array is never reset directly; the sequencer zeroes it one entry per cycle
    always_comb begin
        regs_d = regs_q;
        if (!rst_i) begin
            if (state_q == RF_INIT) begin
                regs_d[clear_idx_q] = '0;
            end else if (we_i && (wr_addr_i != '0)) begin
                regs_d[wr_addr_i] = wr_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        regs_q <= regs_d;
    end

`ifdef RISCV_RF_BYPASS_EN
    assign fwd_vld = we_i && (state_q == RF_READY) && (wr_addr_i != '0);
`else
    assign fwd_vld = 1'b0;
`endif

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
        riscv_rf_read_port #(
            .XLEN          (XLEN),
            .REG_COUNT     (REG_COUNT),
            .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
        ) u_rd_port (
            .regs_i    (regs_q),
            .rd_addr_i (rd_addr_i[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
            .rd_en_i   (state_q == RF_READY),
            .fwd_vld_i (fwd_vld),
            .fwd_addr_i(wr_addr_i),
            .fwd_data_i(wr_data_i),
            .rd_data_o (rd_data_o[p*XLEN +: XLEN])
        );
    end

    assign init_busy_o = init_busy_q;
    assign wr_drop_o   = wr_drop_q;

endmodule

// File: tb/tb_riscv_reg_file_mp.sv
// Directed self-checking bench: default 32x32 two-port instance plus a 16-entry
// three-port instance. Expected bypass result follows RISCV_RF_BYPASS_EN.
module tb_riscv_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy, drop;

    logic        rst2;
    logic [11:0] rd_addr2;
    logic [95:0] rd_data2;
    logic        we2;
    logic [3:0]  wr_addr2;
    logic [31:0] wr_data2;
    logic        busy2, drop2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_reg_file_mp dut (
        .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .we_i(we), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .init_busy_o(busy), .wr_drop_o(drop)
    );

    riscv_reg_file_mp #(.REG_COUNT(16), .NUM_RD_PORTS(3)) dut_small (
        .clk_i(clk), .rst_i(rst2), .rd_addr_i(rd_addr2), .rd_data_o(rd_data2),
        .we_i(we2), .wr_addr_i(wr_addr2), .wr_data_i(wr_data2),
        .init_busy_o(busy2), .wr_drop_o(drop2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        we  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        tick();
        we = 1'b0;
    endtask

    // Counts cycles with busy high starting right after the reset edge
    task automatic count_busy(input string name, input int exp_cycles);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== exp_cycles) begin
            errors++;
            $display("FAIL %s: busy cycles=%0d expected=%0d", name, n, exp_cycles);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        apply_reset();
        checks++;
        if (busy !== 1'b1 || drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b drop=%b expected busy=1 drop=0", busy, drop);
        end
        // Walk read addresses through the clear window; every port must read zero
        while (busy && n < 100) begin
            rd_addr = {5'(n + 7), 5'(n)};
            #1;
            checks++;
            if (rd_data !== 64'h0) begin
                errors++;
                $display("FAIL init_read: cycle=%0d data=%h expected 0", n, rd_data);
            end
            tick();
            n++;
        end
        checks++;
        if (n !== 31) begin
            errors++;
            $display("FAIL init_len: busy cycles=%0d expected=31", n);
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            checks++;
            if (rd_data !== 64'h0) begin
                errors++;
                $display("FAIL cleared_read: addr=%0d data=%h expected 0", a, rd_data);
            end
        end
    endtask

    task automatic test_write();
        write_reg(5'd5, 32'hDEADBEEF);
        rd_addr = {5'd5, 5'd5};
        #1;
        checks++;
        if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL write_x5: data=%h expected deadbeefdeadbeef", rd_data);
        end
        write_reg(5'd0, 32'h1234);
        rd_addr = {5'd5, 5'd0};
        #1;
        checks++;
        if (rd_data !== {32'hDEADBEEF, 32'h0} || drop !== 1'b0) begin
            errors++;
            $display("FAIL write_x0: data=%h drop=%b expected deadbeef00000000 drop=0", rd_data, drop);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hA000_0000 + 32'(i * 3));
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e0, e1;
            e0 = (i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i * 3);
            e1 = (i == 31) ? 32'h0 : 32'hA000_0000 + 32'((31 - i) * 3);
            rd_addr = {5'(31 - i), 5'(i)};
            #1;
            checks++;
            if (rd_data !== {e1, e0}) begin
                errors++;
                $display("FAIL b2b_read: i=%0d data=%h expected %h", i, rd_data, {e1, e0});
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
`ifdef RISCV_RF_BYPASS_EN
        exp_same = 32'hFF;
`else
        exp_same = 32'h11;
`endif
        write_reg(5'd3, 32'h11);
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'hFF;
        rd_addr = {5'd0, 5'd3};
        #1;
        checks++;
        if (rd_data !== {32'h0, exp_same}) begin
            errors++;
            $display("FAIL bypass_same_cycle: data=%h expected %h", rd_data, {32'h0, exp_same});
        end
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hFF) begin
            errors++;
            $display("FAIL bypass_next_cycle: data=%h expected ff", rd_data[31:0]);
        end
        // x0 never forwards
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'h5555;
        rd_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (rd_data !== 64'h0) begin
            errors++;
            $display("FAIL bypass_x0: data=%h expected 0", rd_data);
        end
        tick();
        we = 1'b0;
    endtask

    task automatic test_init_drop();
        apply_reset();
        for (int i = 0; i < 10; i++) tick();
        write_reg(5'd7, 32'hA5A5A5A5);
        checks++;
        if (drop !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse: drop=%b expected 1", drop);
        end
        tick();
        checks++;
        if (drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear: drop=%b expected 0", drop);
        end
        count_busy("drop_busy", 19);
        rd_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rd_data !== 64'h0) begin
            errors++;
            $display("FAIL drop_x7: data=%h expected 0", rd_data);
        end
    endtask

    task automatic test_reset_mid_init();
        write_reg(5'd20, 32'hCAFE);
        rd_addr = {5'd0, 5'd20};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hCAFE) begin
            errors++;
            $display("FAIL mid_pre_x20: data=%h expected cafe", rd_data[31:0]);
        end
        apply_reset();
        for (int i = 0; i < 15; i++) tick();
        apply_reset();
        count_busy("mid_busy", 31);
        rd_addr = {5'd20, 5'd20};
        #1;
        checks++;
        if (rd_data !== 64'h0) begin
            errors++;
            $display("FAIL mid_x20: data=%h expected 0", rd_data);
        end
    endtask

    task automatic test_small();
        int n = 0;
        rst2 = 1'b1; we2 = 1'b0;
        tick();
        rst2 = 1'b0;
        while (busy2 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL small_init: busy cycles=%0d expected=15", n);
        end
        we2 = 1'b1; wr_addr2 = 4'd1; wr_data2 = 32'd1;
        tick();
        wr_addr2 = 4'd15; wr_data2 = 32'd15;
        tick();
        we2 = 1'b0;
        rd_addr2 = {4'd0, 4'd15, 4'd1};
        #1;
        checks++;
        if (rd_data2 !== {32'd0, 32'd15, 32'd1} || drop2 !== 1'b0) begin
            errors++;
            $display("FAIL small_read: data=%h drop=%b expected %h drop=0",
                     rd_data2, drop2, {32'd0, 32'd15, 32'd1});
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        rst2 = 1'b1; we2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; rd_addr2 = '0;
        tick();
        test_reset();
        test_write();
        test_back_to_back();
        test_bypass();
        test_init_drop();
        test_reset_mid_init();
        test_small();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
